// File: rtl/axi_aw_rr_arbiter.sv
// rtl/axi_aw_rr_arbiter.sv - round-robin AW arbiter with W-routing select FIFO and outstanding limit
// Define AXI_ARB_STALL_CNT_EN to add the stall_cnt_o blocked-cycle counter.
module axi_aw_rr_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_TRANS    = 8,
  parameter int W_FIFO_DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       mst_aw_valid_o,
  input  logic                       mst_aw_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] aw_sel_o,
  output logic [$clog2(NUM_REQ)-1:0] w_sel_o,
  output logic                       w_sel_valid_o,
  input  logic                       w_last_hs_i,
`ifdef AXI_ARB_STALL_CNT_EN
  output logic [15:0]                stall_cnt_o,
`endif
  input  logic                       b_hs_i
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_TRANS + 1);
  localparam int OCC_W = $clog2(W_FIFO_DEPTH + 1);
  localparam int PTR_W = (W_FIFO_DEPTH > 1) ? $clog2(W_FIFO_DEPTH) : 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   aw_sel_q;
  logic [SEL_W-1:0]   rr_idx;
  logic [SEL_W-1:0]   winner;
  logic               rr_found;
  logic               win_exists;
  logic               grant_allowed;
  logic               aw_hs;
  logic [CNT_W-1:0]   out_cnt_q;
  logic [SEL_W-1:0]   fifo_mem [W_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]   occ_q;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  assign fifo_full     = (occ_q == OCC_W'(W_FIFO_DEPTH));
  assign fifo_empty    = (occ_q == '0);
  assign grant_allowed = (out_cnt_q < CNT_W'(MAX_TRANS)) && !fifo_full;

  // First asserted request at or after ptr_q, wrapping modulo NUM_REQ.
  always_comb begin
    int               k;
    logic [SEL_W-1:0] kk;
    rr_found = 1'b0;
    rr_idx   = '0;
    k        = 0;
    kk       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kk = SEL_W'(k);
      if (!rr_found && req_valid_i[kk]) begin
        rr_found = 1'b1;
        rr_idx   = kk;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    winner      = rr_idx;
    win_exists  = 1'b0;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        winner     = rr_idx;
        win_exists = grant_allowed && rr_found;
      end
      LOCK: begin
        winner     = aw_sel_q;
        win_exists = 1'b1;
      end
      default: ;
    endcase
    // Reset is asynchronous, so the combinational grant must vanish with it.
    if (rst_i) win_exists = 1'b0;
    mst_aw_valid_o = win_exists && req_valid_i[winner];
    aw_hs          = mst_aw_valid_o && mst_aw_ready_i;
    if (win_exists) req_ready_o[winner] = mst_aw_ready_i;
    aw_sel_o = win_exists ? winner : aw_sel_q;
    if (aw_hs)           state_d = IDLE;
    else if (win_exists) state_d = LOCK;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      aw_sel_q <= '0;
    end else begin
      state_q <= state_d;
      if (win_exists) aw_sel_q <= winner;
      if (aw_hs) ptr_q <= (winner == SEL_W'(NUM_REQ - 1)) ? '0 : winner + SEL_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_cnt_q <= '0;
    end else begin
      if (aw_hs && !(b_hs_i && out_cnt_q != '0))
        out_cnt_q <= out_cnt_q + CNT_W'(1);
      else if (!aw_hs && b_hs_i && out_cnt_q != '0)
        out_cnt_q <= out_cnt_q - CNT_W'(1);
    end
  end

  // A handshake only happens while grant is allowed, so push never sees a full FIFO.
  assign push = aw_hs;
  assign pop  = w_last_hs_i && !fifo_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < W_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= winner;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(W_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(W_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign w_sel_valid_o = !fifo_empty;
  assign w_sel_o       = fifo_empty ? '0 : fifo_mem[rd_ptr_q];

`ifdef AXI_ARB_STALL_CNT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if ((|req_valid_i) && !grant_allowed && stall_cnt_o != 16'hFFFF) begin
      stall_cnt_o <= stall_cnt_o + 16'd1;
    end
  end
`endif

endmodule
